// File: rtl/chat_ram_reader_if.sv
// Bundle of the chat reader's request, RAM read-port and UART TX byte signals.
// The reader binds to the slave modport; its environment uses the master modport.
interface chat_ram_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   msg_len;
    logic [ADDR_WIDTH-1:0] ram_read_addr;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, start_addr, msg_len, ram_data_out, tx_ready,
        output ram_read_addr, tx_data, tx_valid, busy, done
    );

    modport master (
        output start, start_addr, msg_len, ram_data_out, tx_ready,
        input  ram_read_addr, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/chat_ram_reader.sv
// Streams a stored chat message from a synchronous-read RAM to the UART TX byte port.
// Optional macro CHAT_READER_NEWLINE_EN appends CR LF after every message.
module chat_ram_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    chat_ram_reader_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   REM_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef CHAT_READER_NEWLINE_EN
    localparam logic [DATA_WIDTH-1:0] CR_BYTE  = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] LF_BYTE  = DATA_WIDTH'(8'h0A);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SEND   = 3'd3,
        ST_EOL_CR = 3'd4,
        ST_EOL_LF = 3'd5,
        ST_DONE   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SEND   = 3'd3,
        ST_DONE   = 3'd6
    } state_t;
`endif

    state_t                state_r,    state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r,     addr_nxt_s;
    logic [ADDR_WIDTH:0]   rem_r,      rem_nxt_s;
    logic [DATA_WIDTH-1:0] tx_data_r,  tx_data_nxt_s;
    logic                  tx_valid_r, tx_valid_nxt_s;
    logic                  busy_r,     busy_nxt_s;
    logic                  done_r,     done_nxt_s;

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        rem_nxt_s      = rem_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_nxt_s = bus.start_addr;
                    rem_nxt_s  = (bus.msg_len > MAX_LEN) ? MAX_LEN : bus.msg_len;
                    if (bus.msg_len == REM_ZERO) begin
`ifdef CHAT_READER_NEWLINE_EN
                        state_nxt_s    = ST_EOL_CR;
                        tx_data_nxt_s  = CR_BYTE;
                        tx_valid_nxt_s = 1'b1;
                        busy_nxt_s     = 1'b1;
`else
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_FETCH;
                        busy_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_LOAD;
            end
            // RAM data for addr_r is present now, one cycle after FETCH.
            ST_LOAD: begin
                tx_data_nxt_s  = bus.ram_data_out;
                tx_valid_nxt_s = 1'b1;
                state_nxt_s    = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    addr_nxt_s     = addr_r + ADDR_ONE;
                    rem_nxt_s      = rem_r - REM_ONE;
                    tx_valid_nxt_s = 1'b0;
                    if (rem_r == REM_ONE) begin
`ifdef CHAT_READER_NEWLINE_EN
                        state_nxt_s    = ST_EOL_CR;
                        tx_data_nxt_s  = CR_BYTE;
                        tx_valid_nxt_s = 1'b1;
`else
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        busy_nxt_s  = 1'b0;
`endif
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
`ifdef CHAT_READER_NEWLINE_EN
            ST_EOL_CR: begin
                if (bus.tx_ready) begin
                    state_nxt_s   = ST_EOL_LF;
                    tx_data_nxt_s = LF_BYTE;
                end else begin
                    state_nxt_s = ST_EOL_CR;
                end
            end
            ST_EOL_LF: begin
                if (bus.tx_ready) begin
                    state_nxt_s    = ST_DONE;
                    tx_valid_nxt_s = 1'b0;
                    done_nxt_s     = 1'b1;
                    busy_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s = ST_EOL_LF;
                end
            end
`endif
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                tx_valid_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any message without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            rem_r      <= {(ADDR_WIDTH+1){1'b0}};
            tx_data_r  <= {DATA_WIDTH{1'b0}};
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            rem_r      <= rem_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign bus.ram_read_addr = addr_r;
    assign bus.tx_data       = tx_data_r;
    assign bus.tx_valid      = tx_valid_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;

endmodule

// File: tb/tb_chat_ram_reader.sv
// Self-checking bench for chat_ram_reader: cycle-level message model plus directed vectors.
// Build with CHAT_READER_NEWLINE_EN defined to exercise the CR LF variant.
module tb_chat_ram_reader;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;
`ifdef CHAT_READER_NEWLINE_EN
    localparam int EOLN = 2;
`else
    localparam int EOLN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chat_ram_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    chat_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [DEPTH];
    always @(posedge clk) bus.ram_data_out <= mem[bus.ram_read_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Message model: each queued byte carries the idle gap before it becomes valid
    // (2 cycles for RAM bytes after a start/handshake, 0 for the CR/LF trailer).
    logic       m_busy, m_done, m_valid;
    int         m_wait;
    logic [9:0] m_addr;
    logic [7:0] m_q[$];
    int         m_gq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0; m_wait <= 0; m_addr <= 10'd0;
            m_q.delete(); m_gq.delete();
        end else begin
            m_done <= 1'b0;
            if (m_valid && bus.tx_ready) begin
                if (m_gq[0] == 2) m_addr <= m_addr + 10'd1;
                void'(m_q.pop_front());
                void'(m_gq.pop_front());
                m_valid <= 1'b0;
                if (m_q.size() == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_wait  <= m_gq[0];
                    m_valid <= (m_gq[0] == 0);
                end
            end else if (m_busy && !m_valid) begin
                if (m_wait == 1) m_valid <= 1'b1;
                m_wait <= m_wait - 1;
            end else if (!m_busy && !m_done && bus.start) begin
                m_addr <= bus.start_addr;
                for (int i = 0; i < ((bus.msg_len > 11'd1024) ? 1024 : int'(bus.msg_len)); i++) begin
                    m_q.push_back(mem[(int'(bus.start_addr) + i) % DEPTH]);
                    m_gq.push_back(2);
                end
`ifdef CHAT_READER_NEWLINE_EN
                m_q.push_back(8'h0D); m_gq.push_back(0);
                m_q.push_back(8'h0A); m_gq.push_back(0);
`endif
                if (m_q.size() == 0) begin
                    m_done <= 1'b1;
                end else begin
                    m_busy  <= 1'b1;
                    m_wait  <= m_gq[0];
                    m_valid <= (m_gq[0] == 0);
                end
            end
        end
    end

    // Per-cycle comparison against the model, hold-stability check and event logging.
    logic       p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    int         hs_cyc[$], hs_addr[$], done_cyc[$];
    logic [7:0] hs_data[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
            check("rst_tx_data",  32'(bus.tx_data),  32'd0);
            check("rst_busy",     32'(bus.busy),     32'd0);
            check("rst_done",     32'(bus.done),     32'd0);
            check("rst_addr",     32'(bus.ram_read_addr), 32'd0);
        end else begin
            check("tx_valid", 32'(bus.tx_valid), 32'(m_valid));
            check("busy",     32'(bus.busy),     32'(m_busy));
            check("done",     32'(bus.done),     32'(m_done));
            check("ram_read_addr", 32'(bus.ram_read_addr), 32'(m_addr));
            if (m_valid && m_q.size() > 0) check("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
            if (p_rst && p_valid && !p_ready) begin
                check("hold_valid", 32'(bus.tx_valid), 32'd1);
                check("hold_data",  32'(bus.tx_data),  32'(p_data));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                hs_cyc.push_back(cyc);
                hs_data.push_back(bus.tx_data);
                hs_addr.push_back(int'(bus.ram_read_addr));
            end
            if (bus.done) done_cyc.push_back(cyc);
        end
        p_valid <= bus.tx_valid;
        p_ready <= bus.tx_ready;
        p_data  <= bus.tx_data;
        p_rst   <= rst_n;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_msg(input logic [9:0] a, input logic [10:0] len, output int n);
        hs_cyc.delete(); hs_data.delete(); hs_addr.delete(); done_cyc.delete();
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.msg_len    = len;
        n = cyc;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            step(1);
            k++;
        end
        check("done_seen", 32'(done_cyc.size() != 0), 32'd1);
        step(2);
    endtask

    logic [7:0] hi_msg [3];
    logic [7:0] wrap_msg [4];
    int n;

    initial begin
        hi_msg   = '{8'h48, 8'h69, 8'h21};
        wrap_msg = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 7) + 3);
        mem[5] = 8'h48; mem[6] = 8'h69; mem[7] = 8'h21;
        mem[1022] = 8'hA0; mem[1023] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
        bus.start = 1'b0; bus.start_addr = 10'd0; bus.msg_len = 11'd0; bus.tx_ready = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(2);

        // Basic message, continuous ready: bytes at N+3, N+6, N+9
        start_msg(10'd5, 11'd3, n);
        wait_done(100);
        check("t1_count", 32'(hs_cyc.size()), 32'(3 + EOLN));
        if (hs_cyc.size() >= 3)
            for (int i = 0; i < 3; i++) begin
                check("t1_cycle", 32'(hs_cyc[i] - n), 32'(3 + 3 * i));
                check("t1_byte",  32'(hs_data[i]), 32'(hi_msg[i]));
            end
        if (done_cyc.size() > 0) check("t1_done_cycle", 32'(done_cyc[0] - n), 32'(10 + EOLN));

        // Back-pressure on second byte for 4 cycles
        start_msg(10'd5, 11'd3, n);
        step(5);
        bus.tx_ready = 1'b0;
        step(4);
        bus.tx_ready = 1'b1;
        wait_done(100);
        check("t2_count", 32'(hs_cyc.size()), 32'(3 + EOLN));
        if (hs_cyc.size() >= 3) begin
            check("t2_cyc0", 32'(hs_cyc[0] - n), 32'd3);
            check("t2_cyc1", 32'(hs_cyc[1] - n), 32'd10);
            check("t2_cyc2", 32'(hs_cyc[2] - n), 32'd13);
            for (int i = 0; i < 3; i++) check("t2_byte", 32'(hs_data[i]), 32'(hi_msg[i]));
        end
        if (done_cyc.size() > 0) check("t2_done_cycle", 32'(done_cyc[0] - n), 32'(14 + EOLN));

        // Address wrap 1022 -> 1023 -> 0 -> 1
        start_msg(10'd1022, 11'd4, n);
        wait_done(100);
        check("t3_count", 32'(hs_cyc.size()), 32'(4 + EOLN));
        if (hs_cyc.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check("t3_addr", 32'(hs_addr[i]), 32'((1022 + i) % DEPTH));
                check("t3_byte", 32'(hs_data[i]), 32'(wrap_msg[i]));
            end

        // Empty message, then a start in the DONE cycle must be ignored
        start_msg(10'd5, 11'd0, n);
        step(EOLN);
        bus.start = 1'b1; bus.start_addr = 10'd5; bus.msg_len = 11'd3;
        step(1);
        bus.start = 1'b0;
        step(6);
        check("t4_count", 32'(hs_cyc.size()), 32'(EOLN));
        check("t4_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check("t4_done_cycle", 32'(done_cyc[0] - n), 32'(1 + EOLN));
`ifdef CHAT_READER_NEWLINE_EN
        if (hs_cyc.size() == 2) begin
            check("t4_cr", 32'(hs_data[0]), 32'h0D);
            check("t4_lf", 32'(hs_data[1]), 32'h0A);
        end
`endif

        // Start while busy is ignored
        start_msg(10'd5, 11'd3, n);
        step(3);
        bus.start = 1'b1; bus.start_addr = 10'd1022; bus.msg_len = 11'd4;
        step(1);
        bus.start = 1'b0;
        wait_done(100);
        check("t5_count", 32'(hs_cyc.size()), 32'(3 + EOLN));
        if (hs_cyc.size() >= 3)
            for (int i = 0; i < 3; i++) check("t5_byte", 32'(hs_data[i]), 32'(hi_msg[i]));

        // Reset during SEND of byte 2, then a fresh full message
        start_msg(10'd5, 11'd3, n);
        step(5);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(bus.tx_valid), 32'd0);
        check("t6_data",  32'(bus.tx_data),  32'd0);
        check("t6_busy",  32'(bus.busy),     32'd0);
        check("t6_addr",  32'(bus.ram_read_addr), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("t6_no_done", 32'(done_cyc.size()), 32'd0);
        start_msg(10'd5, 11'd3, n);
        wait_done(100);
        check("t6_count", 32'(hs_cyc.size()), 32'(3 + EOLN));
        if (hs_cyc.size() >= 3) begin
            check("t6_first_cycle", 32'(hs_cyc[0] - n), 32'd3);
            for (int i = 0; i < 3; i++) check("t6_byte", 32'(hs_data[i]), 32'(hi_msg[i]));
        end

        // Oversized length clamps to the full RAM depth
        start_msg(10'd0, 11'd2047, n);
        wait_done(4000);
        check("t7_count", 32'(hs_cyc.size()), 32'(DEPTH + EOLN));
        if (hs_cyc.size() >= DEPTH) begin
            check("t7_last_addr", 32'(hs_addr[DEPTH-1]), 32'd1023);
            check("t7_last_byte", 32'(hs_data[DEPTH-1]), 32'h21 ^ 32'h21 ^ 32'(mem[1023]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chat_ram_reader.md
# chat_ram_reader

Read-side sequencer for the UART chat message buffer: on a start pulse it walks a stored message in the 1024×8 synchronous-read chat RAM, absorbs the RAM's one-cycle read latency, and streams each byte to the UART transmitter over a valid/ready handshake. It sits between the chat RAM's read port and the UART TX byte interface; the RAM's write port stays owned by the receive path.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, byte width of RAM and TX data

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to send a message; honoured only in IDLE
- start_addr  in  ADDR_WIDTH  first RAM address of message, sampled with start
- msg_len  in  ADDR_WIDTH+1  byte count, sampled with start; 0 allowed
- ram_read_addr  out  ADDR_WIDTH  to RAM read port, driven from internal address register
- ram_data_out  in  DATA_WIDTH  RAM read data, valid one cycle after address presented
- tx_data  out  DATA_WIDTH  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte when tx_valid && tx_ready
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse when message fully handed off

## Operation
- States: IDLE, FETCH, LOAD, SEND, (EOL_CR, EOL_LF when configured), DONE.
- IDLE: on start, latch addr <= start_addr, remaining <= min(msg_len, 2**ADDR_WIDTH); go FETCH, or DONE directly if msg_len == 0.
- FETCH: ram_read_addr = addr; RAM samples it this edge. Go LOAD.
- LOAD: capture ram_data_out into tx_data register. Go SEND.
- SEND: tx_valid = 1. On handshake: addr <= addr + 1 (mod 2**ADDR_WIDTH, 1023 wraps to 0), remaining <= remaining − 1; if remaining was 1 go DONE (or EOL_CR), else FETCH. Without handshake hold state.
- DONE: done = 1 for exactly this cycle, busy = 0 from this cycle on; go IDLE.
- start outside IDLE is ignored (no queueing). start and msg_len in the same cycle as a DONE→IDLE transition are not seen.
- tx_data and tx_valid never change while tx_valid && !tx_ready.
- ram_read_addr holds its last value when idle; RAM writes to the address being read follow the RAM's read-old-data behaviour and are not guarded here.

## Timing
- Reset values: ram_read_addr = 0, tx_data = 0, tx_valid = 0, busy = 0, done = 0; state IDLE, counters 0. Reset mid-message aborts immediately with no done pulse.
- start at cycle N: busy = 1 and FETCH at N+1, LOAD at N+2, tx_valid = 1 at N+3.
- With tx_ready held high: one byte per 3 cycles; final handshake at cycle M → done = 1 at M+1, busy = 0 at M+1, new start accepted at M+2.
- msg_len = 0: done at N+1, busy never asserted, tx_valid never asserted.
- All outputs registered; no combinational path from tx_ready to any output.

## Configuration
- Macro CHAT_READER_NEWLINE_EN.
- Defined: after the last message byte, send 0x0D (EOL_CR) then 0x0A (EOL_LF), each held with tx_valid until handshake; done follows the LF handshake by one cycle. msg_len = 0 still sends CR LF.
- Undefined: EOL states absent; DONE follows the last message byte; msg_len = 0 sends nothing.

## Test plan
- RAM[5..7] = 0x48,0x69,0x21, start_addr 5, msg_len 3, tx_ready = 1 → bytes 0x48,0x69,0x21 at cycles N+3, N+6, N+9; done at N+10.
- Same message, tx_ready low 4 cycles on second byte → 0x69 held stable on tx_data with tx_valid = 1 throughout, sequence intact, done delayed by 4 cycles.
- start_addr 1022, msg_len 4 → ram_read_addr sequence 1022, 1023, 0, 1; four bytes sent in order.
- msg_len 0 → done at N+1, no tx_valid (macro undefined); with CHAT_READER_NEWLINE_EN, 0x0D then 0x0A then done.
- start pulsed while busy with different start_addr → ignored, original message completes unchanged.
- rst_n low during SEND of byte 2 of 3 → all outputs 0 asynchronously, no done; fresh start afterwards sends full message from byte 1.
